// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are ordered {CA,CB,CC,CD,CE,CF,CG}, active-low.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Index 15 first so that SEG_PATTERNS[h] is the pattern for hex digit h.
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_e;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex-to-seven-segment decoder, CA..CG active-low.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_PATTERNS[hex];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with a one-deep staging register.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SLOT_CYCLES  = 12_500,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                      CLK100MHZ,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*NUM_DIGITS-1:0]   in_digits,
    input  logic [NUM_DIGITS-1:0]     in_dp,
    input  logic [NUM_DIGITS-1:0]     in_en,
    output logic [NUM_DIGITS-1:0]     AN,
    output logic [7:0]                SEG,
    output logic                      frame_start
);

    localparam int unsigned CntW = $clog2(SLOT_CYCLES);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("NUM_DIGITS must be in 1..8");
    end
    if (SLOT_CYCLES < 2) begin : g_bad_slot_cycles
        $error("SLOT_CYCLES must be at least 2");
    end
    if (BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank_cycles
        $error("BLANK_CYCLES must be less than SLOT_CYCLES");
    end

    logic [CntW-1:0]           slot_q, slot_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic                      pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0]   stage_digits_q, stage_digits_d;
    logic [NUM_DIGITS-1:0]     stage_dp_q, stage_dp_d;
    logic [NUM_DIGITS-1:0]     stage_en_q, stage_en_d;
    logic [4*NUM_DIGITS-1:0]   act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]     act_en_q, act_en_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic [7:0]                seg_q, seg_d;
    logic                      frame_start_q, frame_start_d;

    logic                      slot_wrap;
    logic                      boundary;
    logic                      accept;
    scan_state_e               scan_state;
    logic [3:0]                cur_digit;
    logic                      cur_dp;
    logic                      cur_en;
    logic                      cur_lz;
    logic [NUM_DIGITS-1:0]     cur_onehot;
    logic [6:0]                cur_pattern;
    logic [NUM_DIGITS-1:0]     lz_mask;

    assign in_ready = ~pending_q & ~RST;
    assign accept   = in_valid & in_ready;

    assign slot_wrap  = (slot_q == CntW'(SLOT_CYCLES - 1));
    assign boundary   = slot_wrap && (idx_q == IdxW'(NUM_DIGITS - 1));
    assign scan_state = (slot_q < CntW'(BLANK_CYCLES)) ? BLANK : DRIVE;

`ifdef SEG7_LZ_BLANK_EN
    // A digit is a leading zero when it and every enabled digit above it are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (act_en_q[i] && (act_digits_q[4*i +: 4] != 4'h0)) begin
                zero_above = 1'b0;
            end
            lz_mask[i] = zero_above && (i != 0);
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        cur_digit  = 4'h0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        cur_lz     = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_digit     = act_digits_q[4*i +: 4];
                cur_dp        = act_dp_q[i];
                cur_en        = act_en_q[i];
                cur_lz        = lz_mask[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    hex_to_7seg u_decode (
        .hex (cur_digit),
        .seg (cur_pattern)
    );

    always_comb begin
        slot_d         = slot_q;
        idx_d          = idx_q;
        pending_d      = pending_q;
        stage_digits_d = stage_digits_q;
        stage_dp_d     = stage_dp_q;
        stage_en_d     = stage_en_q;
        act_digits_d   = act_digits_q;
        act_dp_d       = act_dp_q;
        act_en_d       = act_en_q;
        an_d           = '1;
        seg_d          = SEG_OFF;
        frame_start_d  = boundary;

        if (slot_wrap) begin
            slot_d = '0;
            idx_d  = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end else begin
            slot_d = slot_q + CntW'(1);
        end

        // Commit uses the pending flag from before this cycle; a boundary accept
        // only stages and waits for the next frame.
        if (boundary && pending_q) begin
            act_digits_d = stage_digits_q;
            act_dp_d     = stage_dp_q;
            act_en_d     = stage_en_q;
            pending_d    = 1'b0;
        end
        if (accept) begin
            stage_digits_d = in_digits;
            stage_dp_d     = in_dp;
            stage_en_d     = in_en;
            pending_d      = 1'b1;
        end

        if (scan_state == DRIVE && cur_en && !cur_lz) begin
            an_d  = ~cur_onehot;
            seg_d = {cur_pattern, ~cur_dp};
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            slot_q         <= '0;
            idx_q          <= '0;
            pending_q      <= 1'b0;
            stage_digits_q <= '0;
            stage_dp_q     <= '0;
            stage_en_q     <= '0;
            act_digits_q   <= '0;
            act_dp_q       <= '0;
            act_en_q       <= '0;
            an_q           <= '1;
            seg_q          <= SEG_OFF;
            frame_start_q  <= 1'b0;
        end else begin
            slot_q         <= slot_d;
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            stage_digits_q <= stage_digits_d;
            stage_dp_q     <= stage_dp_d;
            stage_en_q     <= stage_en_d;
            act_digits_q   <= act_digits_d;
            act_dp_q       <= act_dp_d;
            act_en_q       <= act_en_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign AN          = an_q;
    assign SEG         = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seg7_scan_driver;

    logic        CLK100MHZ = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_digits;
    logic [3:0]  in_dp;
    logic [3:0]  in_en;
    logic [3:0]  AN;
    logic [7:0]  SEG;
    logic        frame_start;

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .SLOT_CYCLES  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .CLK100MHZ   (CLK100MHZ),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_digits   (in_digits),
        .in_dp       (in_dp),
        .in_en       (in_en),
        .AN          (AN),
        .SEG         (SEG),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    // Runs ncyc cycles from scan state 0 and checks every output each cycle.
    // an_e/seg_e are the hand-computed drive values per digit {d3,d2,d1,d0}.
    task automatic run_frame(input string tag, input int ncyc,
                             input logic [3:0][3:0] an_e, input logic [3:0][7:0] seg_e,
                             input bit carry, input int acc_at, input logic [15:0] acc_d,
                             input logic [3:0] acc_dp, input logic [3:0] acc_en,
                             input int junk_at);
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        logic       exp_rdy;
        for (int s = 0; s < ncyc; s++) begin
            if (s == acc_at) begin
                in_valid = 1'b1; in_digits = acc_d; in_dp = acc_dp; in_en = acc_en;
            end else if (s == junk_at) begin
                in_valid = 1'b1; in_digits = 16'hFFFF; in_dp = 4'hF; in_en = 4'hF;
            end else begin
                in_valid = 1'b0; in_digits = 16'h0000; in_dp = 4'h0; in_en = 4'h0;
            end
            step();
            exp_an  = ((s % 8) < 2) ? 4'hF  : an_e[s / 8];
            exp_seg = ((s % 8) < 2) ? 8'hFF : seg_e[s / 8];
            exp_rdy = !((carry && s < 31) ||
                        (acc_at >= 0 && s >= acc_at && (s < 31 || acc_at == 31)));
            check($sformatf("%s an s%0d", tag, s), {28'd0, AN}, {28'd0, exp_an});
            check($sformatf("%s seg s%0d", tag, s), {24'd0, SEG}, {24'd0, exp_seg});
            check($sformatf("%s fs s%0d", tag, s), {31'd0, frame_start}, {31'd0, s == 31});
            check($sformatf("%s rdy s%0d", tag, s), {31'd0, in_ready}, {31'd0, exp_rdy});
        end
        in_valid = 1'b0;
    endtask

    // Hand-computed digit images.
    localparam logic [3:0][3:0] AnDark  = {4'hF, 4'hF, 4'hF, 4'hF};
    localparam logic [3:0][7:0] SegDark = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    // A = 16'h1708, dp 0000, en F: digits 8,0,7,1
    localparam logic [3:0][3:0] AnA  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0][7:0] SegA = {8'b1001_1111, 8'b0001_1111, 8'b0000_0011, 8'b0000_0001};
    // B = 16'h9C3F, dp 0101, en 1011: digit 2 dark
    localparam logic [3:0][3:0] AnB  = {4'b0111, 4'b1111, 4'b1101, 4'b1110};
    localparam logic [3:0][7:0] SegB = {8'b0000_1001, 8'hFF, 8'b0000_1101, 8'b0111_0000};
    // C = 16'h6BAD, dp 1000, en F
    localparam logic [3:0][3:0] AnC  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0][7:0] SegC = {8'b0100_0000, 8'b1100_0001, 8'b0001_0001, 8'b1000_0101};
    // E = 16'h0050, dp 0000, en F
`ifdef SEG7_LZ_BLANK_EN
    localparam logic [3:0][3:0] AnE  = {4'b1111, 4'b1111, 4'b1101, 4'b1110};
    localparam logic [3:0][7:0] SegE = {8'hFF, 8'hFF, 8'b0100_1001, 8'b0000_0011};
`else
    localparam logic [3:0][3:0] AnE  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0][7:0] SegE = {8'b0000_0011, 8'b0000_0011, 8'b0100_1001, 8'b0000_0011};
`endif

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_digits = '0; in_dp = '0; in_en = '0;
        repeat (3) step();
        check("rst an", {28'd0, AN}, 32'hF);
        check("rst seg", {24'd0, SEG}, 32'hFF);
        check("rst fs", {31'd0, frame_start}, 32'd0);
        check("rst rdy_low", {31'd0, in_ready}, 32'd0);
        RST = 1'b0;
        #1;
        check("rel rdy", {31'd0, in_ready}, 32'd1);

        // Frame 0: nothing active yet; load A, first frame_start 32 cycles after release.
        run_frame("f0", 32, AnDark, SegDark, 1'b0, 0, 16'h1708, 4'b0000, 4'hF, -1);
        // Frame 1: A shown; B accepted mid-frame, a later offer is ignored.
        run_frame("f1", 32, AnA, SegA, 1'b0, 10, 16'h9C3F, 4'b0101, 4'b1011, 15);
        // Frame 2: B shown; C accepted in the boundary cycle.
        run_frame("f2", 32, AnB, SegB, 1'b0, 31, 16'h6BAD, 4'b1000, 4'hF, -1);
        // Frame 3: boundary accept only staged, B still shown.
        run_frame("f3", 32, AnB, SegB, 1'b1, -1, 16'h0, 4'h0, 4'h0, -1);
        run_frame("f4", 32, AnC, SegC, 1'b0, -1, 16'h0, 4'h0, 4'h0, -1);
        // Partial frame into digit 2, with D pending, then reset.
        run_frame("f5", 19, AnC, SegC, 1'b0, 3, 16'h1111, 4'h0, 4'hF, -1);
        RST = 1'b1;
        #1;
        check("mid rst rdy_low", {31'd0, in_ready}, 32'd0);
        step();
        RST = 1'b0;
        #1;
        check("mid rst an", {28'd0, AN}, 32'hF);
        check("mid rst seg", {24'd0, SEG}, 32'hFF);
        check("mid rst fs", {31'd0, frame_start}, 32'd0);
        check("mid rst rdy", {31'd0, in_ready}, 32'd1);
        // D must be lost: the restarted frame is dark and commits nothing of D.
        run_frame("f6", 32, AnDark, SegDark, 1'b0, 0, 16'h0050, 4'b0000, 4'hF, -1);
        run_frame("f7", 32, AnE, SegE, 1'b0, -1, 16'h0, 4'h0, 4'h0, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
